// File: rtl/id_control_unit.sv
// Decode-stage control unit: combinational instruction decode with ARM condition
// evaluation against a registered NZCV flag register, plus bubble squash and PC+4.
module id_control_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] pc_in,
    input  logic [3:0]  flags_in,
    input  logic        flags_write,
    input  logic        nop_select,
    output logic [31:0] pc_plus_4,
    output logic        reg_write_enable,
    output logic        mem_write_enable,
    output logic        mem_to_reg_select,
    output logic        alu_source_select,
    output logic [1:0]  status_bits,
    output logic [1:0]  alu_operation,
    output logic        pc_source_select,
    output logic [3:0]  flags
);

    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       cond_ok;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic pass;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    pass = z;
            4'h1:    pass = ~z;
            4'h2:    pass = c;
            4'h3:    pass = ~c;
            4'h4:    pass = n;
            4'h5:    pass = ~n;
            4'h6:    pass = v;
            4'h7:    pass = ~v;
            4'h8:    pass = c & ~z;
            4'h9:    pass = ~c | z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = ~z & (n == v);
            4'hD:    pass = z | (n != v);
            4'hE:    pass = 1'b1;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

    function automatic logic [1:0] dp_alu_op(input logic [3:0] opcode);
        logic [1:0] op;
        case (opcode)
            4'b0000:         op = 2'b10;
            4'b0010, 4'b1010: op = 2'b01;
            4'b1100:         op = 2'b11;
            default:         op = 2'b00;
        endcase
        return op;
    endfunction

    always_comb begin
        flags_d = flags_write ? flags_in : flags_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign pc_plus_4 = pc_in + 32'd4;
    assign flags     = flags_q;
    assign cond_ok   = cond_pass(instruction[31:28], flags_q);

    always_comb begin
        reg_write_enable  = 1'b0;
        mem_write_enable  = 1'b0;
        mem_to_reg_select = 1'b0;
        alu_source_select = 1'b0;
        status_bits       = 2'b00;
        alu_operation     = 2'b00;
        pc_source_select  = 1'b0;

        // An all-zero word is a NOP even though it looks like ANDEQ R0,R0,R0.
        if (instruction != 32'h0000_0000) begin
            case (instruction[27:25])
                3'b000, 3'b001: begin
                    reg_write_enable  = (instruction[24:23] != 2'b10);
                    alu_source_select = instruction[25];
                    status_bits       = {1'b0, instruction[20]};
                    alu_operation     = dp_alu_op(instruction[24:21]);
                end
                3'b010, 3'b011: begin
                    alu_source_select = ~instruction[25];
                    alu_operation     = instruction[23] ? 2'b00 : 2'b01;
                    reg_write_enable  = instruction[20];
                    mem_to_reg_select = instruction[20];
                    mem_write_enable  = ~instruction[20];
                end
                3'b101: begin
                    pc_source_select  = 1'b1;
                    alu_source_select = 1'b1;
                    reg_write_enable  = instruction[24];
                    status_bits       = {instruction[24], 1'b0};
                end
                default: ;
            endcase

            // A failed condition suppresses architectural side effects only.
            if (!cond_ok) begin
                reg_write_enable = 1'b0;
                mem_write_enable = 1'b0;
                pc_source_select = 1'b0;
                status_bits      = 2'b00;
            end
        end

        if (nop_select) begin
            reg_write_enable  = 1'b0;
            mem_write_enable  = 1'b0;
            mem_to_reg_select = 1'b0;
            alu_source_select = 1'b0;
            status_bits       = 2'b00;
            alu_operation     = 2'b00;
            pc_source_select  = 1'b0;
        end
    end

endmodule

// File: tb/tb_id_control_unit.sv
// Bench for id_control_unit: decode vector table, condition-code sweeps over several
// flag settings, and hand-written flag timing / reset sequences.
module tb_id_control_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] pc_in;
    logic [3:0]  flags_in;
    logic        flags_write;
    logic        nop_select;
    logic [31:0] pc_plus_4;
    logic        reg_write_enable;
    logic        mem_write_enable;
    logic        mem_to_reg_select;
    logic        alu_source_select;
    logic [1:0]  status_bits;
    logic [1:0]  alu_operation;
    logic        pc_source_select;
    logic [3:0]  flags;

    id_control_unit dut (
        .clk               (clk),
        .reset             (reset),
        .instruction       (instruction),
        .pc_in             (pc_in),
        .flags_in          (flags_in),
        .flags_write       (flags_write),
        .nop_select        (nop_select),
        .pc_plus_4         (pc_plus_4),
        .reg_write_enable  (reg_write_enable),
        .mem_write_enable  (mem_write_enable),
        .mem_to_reg_select (mem_to_reg_select),
        .alu_source_select (alu_source_select),
        .status_bits       (status_bits),
        .alu_operation     (alu_operation),
        .pc_source_select  (pc_source_select),
        .flags             (flags)
    );

    always #5 clk = ~clk;

    // ctrl packing: {reg_write, mem_write, mem_to_reg, alu_src, status[1:0], alu_op[1:0], pc_src}
    logic [8:0] ctrl_act;
    assign ctrl_act = {reg_write_enable, mem_write_enable, mem_to_reg_select, alu_source_select,
                       status_bits, alu_operation, pc_source_select};

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        nop;
        logic [8:0]  ctrl;
        logic [31:0] pc4;
    } vec_t;

    vec_t tbl[$];
    vec_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [8:0] BL_PASS = 9'b1_0_0_1_10_00_1;
    localparam logic [8:0] BL_FAIL = 9'b0_0_0_1_00_00_0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_out();
        vec_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got nothing expected an entry");
            return;
        end
        e = sb_q.pop_front();
        chk({e.name, "_ctrl"}, {23'b0, ctrl_act}, {23'b0, e.ctrl});
        chk({e.name, "_pc4"}, pc_plus_4, e.pc4);
    endtask

    task automatic drive_vec(input vec_t v);
        instruction = v.instr;
        pc_in       = v.pc;
        nop_select  = v.nop;
        sb_q.push_back(v);
        @(negedge clk);
        check_out();
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_in    = f;
        flags_write = 1'b1;
        @(posedge clk);
        #1;
        flags_write = 1'b0;
        chk($sformatf("flags_load_%h", f), {28'b0, flags}, {28'b0, f});
    endtask

    task automatic cond_sweep(input logic [3:0] f, input logic [15:0] mask);
        vec_t v;
        logic [3:0] cc;
        set_flags(f);
        for (int c = 0; c < 16; c++) begin
            cc      = c[3:0];
            v.name  = $sformatf("cond%h_f%h", cc, f);
            v.instr = {cc, 28'hB00_0010};
            v.pc    = $urandom;
            v.nop   = 1'b0;
            v.ctrl  = mask[c] ? BL_PASS : BL_FAIL;
            v.pc4   = v.pc + 32'd4;
            drive_vec(v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tbl.push_back(vec_t'{"ands_imm",  32'hE211_0000, 32'h0000_1000, 1'b0, 9'b1_0_0_1_01_10_0, 32'h0000_1004});
        tbl.push_back(vec_t'{"add_reg",   32'hE080_5183, 32'h0000_0000, 1'b0, 9'b1_0_0_0_00_00_0, 32'h0000_0004});
        tbl.push_back(vec_t'{"ldrb",      32'hE7D1_2000, 32'h7FFF_FFFC, 1'b0, 9'b1_0_1_0_00_00_0, 32'h8000_0000});
        tbl.push_back(vec_t'{"str",       32'hE58A_5000, 32'hFFFF_FFF8, 1'b0, 9'b0_1_0_1_00_00_0, 32'hFFFF_FFFC});
        tbl.push_back(vec_t'{"bne_z0",    32'h1AFF_FFFD, 32'h0000_2000, 1'b0, 9'b0_0_0_1_00_00_1, 32'h0000_2004});
        tbl.push_back(vec_t'{"blle_z0",   32'hDB00_0009, 32'h0000_2004, 1'b0, 9'b0_0_0_1_00_00_0, 32'h0000_2008});
        tbl.push_back(vec_t'{"nop_word",  32'h0000_0000, 32'h0000_0100, 1'b0, 9'b0_0_0_0_00_00_0, 32'h0000_0104});
        tbl.push_back(vec_t'{"andeq_r1",  32'h0000_0001, 32'h0000_0100, 1'b0, 9'b0_0_0_0_00_10_0, 32'h0000_0104});
        tbl.push_back(vec_t'{"subs",      32'hE051_0002, 32'h1234_5678, 1'b0, 9'b1_0_0_0_01_01_0, 32'h1234_567C});
        tbl.push_back(vec_t'{"cmp_imm",   32'hE350_0001, 32'h0000_0010, 1'b0, 9'b0_0_0_1_01_01_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"cmn_reg",   32'hE170_0001, 32'h0000_0010, 1'b0, 9'b0_0_0_0_01_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"orr_imm",   32'hE380_0001, 32'h0000_0010, 1'b0, 9'b1_0_0_1_00_11_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"tst_reg",   32'hE110_0002, 32'h0000_0010, 1'b0, 9'b0_0_0_0_01_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"teq_imm",   32'hE330_0001, 32'h0000_0010, 1'b0, 9'b0_0_0_1_01_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"eor_reg",   32'hE020_0001, 32'h0000_0010, 1'b0, 9'b1_0_0_0_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"mov_imm",   32'hE3A0_0005, 32'h0000_0010, 1'b0, 9'b1_0_0_1_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"rsb_reg",   32'hE060_0001, 32'h0000_0010, 1'b0, 9'b1_0_0_0_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"ldr_down",  32'hE511_0004, 32'h0000_0010, 1'b0, 9'b1_0_1_1_00_01_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"str_regdn", 32'hE700_0001, 32'h0000_0010, 1'b0, 9'b0_1_0_0_00_01_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"b_al",      32'hEA00_0000, 32'h0000_0010, 1'b0, 9'b0_0_0_1_00_00_1, 32'h0000_0014});
        tbl.push_back(vec_t'{"bl_al",     32'hEB00_0010, 32'h0000_0010, 1'b0, 9'b1_0_0_1_10_00_1, 32'h0000_0014});
        tbl.push_back(vec_t'{"ldm",       32'hE8BD_0001, 32'h0000_0010, 1'b0, 9'b0_0_0_0_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"cop_110",   32'hEC00_0000, 32'h0000_0010, 1'b0, 9'b0_0_0_0_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"swi_111",   32'hEF00_0000, 32'h0000_0010, 1'b0, 9'b0_0_0_0_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"ldreq_ff",  32'h07D1_2000, 32'h0000_0010, 1'b0, 9'b0_0_1_0_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"andseq_ff", 32'h0211_0000, 32'h0000_0010, 1'b0, 9'b0_0_0_1_00_10_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"streq_ff",  32'h058A_5000, 32'h0000_0010, 1'b0, 9'b0_0_0_1_00_00_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"ands_nv",   32'hF211_0000, 32'h0000_0010, 1'b0, 9'b0_0_0_1_00_10_0, 32'h0000_0014});
        tbl.push_back(vec_t'{"nop_ands",  32'hE211_0000, 32'hFFFF_FFFC, 1'b1, 9'b0_0_0_0_00_00_0, 32'h0000_0000});
        tbl.push_back(vec_t'{"nop_bl",    32'hEB00_0010, 32'h0000_0040, 1'b1, 9'b0_0_0_0_00_00_0, 32'h0000_0044});

        reset       = 1'b1;
        flags_write = 1'b1;
        flags_in    = 4'hF;
        instruction = 32'h0;
        pc_in       = 32'h0;
        nop_select  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_beats_flags_write", {28'b0, flags}, 32'h0);
        drive_vec(vec_t'{"reset_nop_word", 32'h0000_0000, 32'h0, 1'b0, 9'b0, 32'h4});
        reset       = 1'b0;
        flags_write = 1'b0;
        @(negedge clk);
        chk("flags_after_reset", {28'b0, flags}, 32'h0);

        foreach (tbl[i]) drive_vec(tbl[i]);
        chk("flags_unchanged_by_nop", {28'b0, flags}, 32'h0);

        set_flags(4'h4);
        drive_vec(vec_t'{"blle_z1", 32'hDB00_0009, 32'h0, 1'b0, 9'b1_0_0_1_10_00_1, 32'h4});
        drive_vec(vec_t'{"bne_z1",  32'h1AFF_FFFD, 32'h0, 1'b0, 9'b0_0_0_1_00_00_0, 32'h4});

        cond_sweep(4'h0, 16'h56AA);
        cond_sweep(4'h4, 16'h66A9);
        cond_sweep(4'h2, 16'h55A6);
        cond_sweep(4'h8, 16'h6A9A);
        cond_sweep(4'h9, 16'h565A);
        cond_sweep(4'h3, 16'h6966);
        cond_sweep(4'h6, 16'h66A5);

        // New flags must not affect decode until after the loading edge.
        set_flags(4'h4);
        instruction = 32'h1AFF_FFFD;
        nop_select  = 1'b0;
        flags_in    = 4'h0;
        flags_write = 1'b1;
        #1;
        chk("bne_before_edge", {31'b0, pc_source_select}, 32'h0);
        @(posedge clk);
        #1;
        flags_write = 1'b0;
        chk("bne_after_edge", {31'b0, pc_source_select}, 32'h1);
        chk("flags_after_edge", {28'b0, flags}, 32'h0);

        set_flags(4'hA);
        flags_in = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        chk("flags_hold", {28'b0, flags}, 32'hA);

        // Reset mid-operation: decode stays live while reset is high.
        set_flags(4'h4);
        drive_vec(vec_t'{"bne_pre_reset", 32'h1AFF_FFFD, 32'h0, 1'b0, BL_FAIL, 32'h4});
        reset       = 1'b1;
        flags_write = 1'b1;
        flags_in    = 4'hF;
        drive_vec(vec_t'{"ands_in_reset", 32'hE211_0000, 32'h8, 1'b0, 9'b1_0_0_1_01_10_0, 32'hC});
        chk("flags_mid_reset", {28'b0, flags}, 32'h0);
        drive_vec(vec_t'{"bne_in_reset", 32'h1AFF_FFFD, 32'h8, 1'b0, 9'b0_0_0_1_00_00_1, 32'hC});
        reset       = 1'b0;
        flags_write = 1'b0;
        @(negedge clk);

        chk("scoreboard_drained", sb_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/id_control_unit.md
ID_CONTROL_UNIT -- requirements
Module: id_control_unit

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instruction  input  32  instruction word from the IF/ID register.
REQ-005 pc_in  input  32  current program counter.
REQ-006 flags_in  input  4  new NZCV condition flags, bit3=N, bit2=Z, bit1=C, bit0=V.
REQ-007 flags_write  input  1  load flags_in into the flag register.
REQ-008 nop_select  input  1  1 = squash all control outputs (bubble insertion).
REQ-009 pc_plus_4  output  32  pc_in + 4.
REQ-010 reg_write_enable  output  1  register file write.
REQ-011 mem_write_enable  output  1  data memory write.
REQ-012 mem_to_reg_select  output  1  1 = write-back from memory, 0 = from ALU.
REQ-013 alu_source_select  output  1  1 = immediate operand, 0 = register operand.
REQ-014 status_bits  output  2  bit0 = flag-update request (S), bit1 = branch link.
REQ-015 alu_operation  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-016 pc_source_select  output  1  1 = take branch target.
REQ-017 flags  output  4  registered NZCV flags.

Function
REQ-018 pc_plus_4 SHALL be combinational pc_in + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-019 Decode and mux SHALL be purely combinational from instruction, flags register and nop_select; zero-cycle latency.
REQ-020 Condition field instruction[31:28] SHALL be evaluated against the registered flags per ARM: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 never.
REQ-021 Instruction 0x00000000 SHALL decode as NOP: all control outputs 0.
REQ-022 Data processing ([27:26]=00): reg_write=1 except opcode[24:21]=10xx (TST/TEQ/CMP/CMN) -> 0; mem_write=0; mem_to_reg=0; alu_source=instr[25]; status_bits={0,instr[20]}; pc_source=0.
REQ-023 DP alu_operation: AND 0000->10, SUB 0010/CMP 1010->01, ADD 0100/CMN 1011->00, ORR 1100->11, all other opcodes->00.
REQ-024 Load/store ([27:26]=01): alu_source=~instr[25]; alu_operation = instr[23] ? 00 : 01; L=instr[20]=1 -> reg_write=1, mem_to_reg=1, mem_write=0; L=0 -> mem_write=1, reg_write=0, mem_to_reg=0; status_bits=00; pc_source=0.
REQ-025 Branch ([27:25]=101): pc_source=1; alu_source=1; alu_operation=00; reg_write=instr[24] (BL); status_bits={instr[24],0}; mem_write=0; mem_to_reg=0.
REQ-026 Other encodings ([27:25]=100, 11x) SHALL produce all control outputs 0.
REQ-027 Condition fail SHALL force reg_write, mem_write, pc_source and status_bits to 0; alu_operation, alu_source, mem_to_reg remain as decoded.
REQ-028 nop_select=1 SHALL force all seven control outputs to 0 regardless of instruction or condition; pc_plus_4 and flags unaffected.
REQ-029 Flag register SHALL load flags_in on rising clk when flags_write=1; otherwise hold.
REQ-030 Condition evaluation SHALL use the registered flags; a flags_write takes effect for decode on the cycle after the edge.

Reset
REQ-031 reset=1 at a rising edge SHALL clear flags to 0000; reset has priority over simultaneous flags_write.
REQ-032 Combinational outputs SHALL depend only on inputs and flags during reset (no output gating).
REQ-033 Reset asserted mid-operation SHALL clear flags at the next edge; condition results change accordingly the same cycle after.

Verification
REQ-034 reset, instruction=0xE2110000 (ANDS R0,R1,#0) -> reg_write=1 mem_write=0 mem_to_reg=0 alu_source=1 status=01 alu_op=10 pc_source=0.
REQ-035 0xE0805183 (ADD) -> 1,0,0,0,00,00,0; 0xE7D12000 (LDRB) -> reg_write=1 mem_to_reg=1 alu_source=0 alu_op=00; 0xE58A5000 (STR) -> mem_write=1 reg_write=0 alu_source=1.
REQ-036 flags=0000: 0x1AFFFFFD (BNE) -> pc_source=1 reg_write=0; 0xDB000009 (BLLE) -> all squashed (pc_source=0 reg_write=0 status=00).
REQ-037 flags_write=1 flags_in=0100, clock, 0xDB000009 -> pc_source=1 reg_write=1 status=10; 0x1AFFFFFD -> pc_source=0.
REQ-038 nop_select=1 with 0xE2110000 -> all control outputs 0; pc_in=0xFFFFFFFC -> pc_plus_4=0x00000000.
REQ-039 flags_write=1 and reset=1 same edge -> flags=0000; instruction=0x00000000 -> all control outputs 0.
